swd_frontend_top: RTL and testbench

//  SPI-to-SWD bit-level front end sitting between the host SPI master and the target SWD pins.

---
 rtl/swd_frontend_pkg.sv | 26 ++
 rtl/swd_bit_counter.sv | 22 ++
 rtl/swd_frontend_top.sv | 71 +++++++
 tb/tb_swd_frontend_top.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/swd_frontend_pkg.sv
// Frame geometry and ACK decoding shared by the SPI-to-SWD front end.
package swd_frontend_pkg;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned ACK_W = 3;

  typedef logic [CNT_W-1:0] bit_idx_t;
  typedef logic [ACK_W-1:0] ack_t;

  localparam bit_idx_t BIT_REQ_FIRST = 6'd2;
  localparam bit_idx_t BIT_TURN1     = 6'd10;
  localparam bit_idx_t BIT_ACK0      = 6'd11;
  localparam bit_idx_t BIT_ACK1      = 6'd12;
  localparam bit_idx_t BIT_ACK2      = 6'd13;
  localparam bit_idx_t BIT_TURN2     = 6'd14;
  localparam bit_idx_t BIT_DATA0     = 6'd15;
  localparam bit_idx_t BIT_PARITY    = 6'd47;
  localparam bit_idx_t FRAME_BITS    = 6'd48;

  localparam ack_t ACK_OK = 3'b001;

  function automatic logic ack_is_ok(input ack_t ack);
    return ack == ACK_OK;
  endfunction

endpackage

// File: rtl/swd_bit_counter.sv
// Frame bit index: synchronous clear, counts sck rising edges, parks at FRAME_BITS.
module swd_bit_counter
  import swd_frontend_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  output bit_idx_t o_cnt
);

  bit_idx_t r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt != FRAME_BITS) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/swd_frontend_top.sv
// SPI-to-SWD bit-level front end: clock passthrough, SWDIO ownership per frame bit,
// ACK capture and write-data gating on ACK=OK.
module swd_frontend_top
  import swd_frontend_pkg::*;
(
  input  logic sck,
  input  logic rst_n,
  input  logic mosi,
  input  logic rnw,
  output logic miso,
  output logic swclk,
  inout  wire  swdio
);

  bit_idx_t bit_cnt;
  logic     swdio_oe_n;
  logic     ack0;
  logic     ack1;
  logic     ack2;
  logic     ack_ok_n;
  logic     y2_n;
  logic     y3_n;
  logic     y4_n;
  logic     y5_n;
  logic     w_ack_win;

  swd_bit_counter u_bit_counter (
    .i_clk   (sck),
    .i_rst_n (rst_n),
    .o_cnt   (bit_cnt)
  );

  // Active-low one-hot decode of TURN1 and the three ACK bit periods.
  assign y2_n      = ~(bit_cnt == BIT_TURN1);
  assign y3_n      = ~(bit_cnt == BIT_ACK0);
  assign y4_n      = ~(bit_cnt == BIT_ACK1);
  assign y5_n      = ~(bit_cnt == BIT_ACK2);
  assign w_ack_win = ~(y2_n & y3_n & y4_n & y5_n);

  // ACK bits are sampled off the pin on the rising edge that closes each ACK period.
  always_ff @(posedge sck) begin
    if (!rst_n) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      ack2 <= 1'b0;
    end else begin
      if (!y3_n) ack0 <= swdio;
      if (!y4_n) ack1 <= swdio;
      if (!y5_n) ack2 <= swdio;
    end
  end

  assign ack_ok_n = ~ack_is_ok({ack2, ack1, ack0});

  // Host owns the line for PAD/REQ, and for write data only after ACK=OK.
  always_comb begin
    swdio_oe_n = 1'b0;
    if (bit_cnt >= FRAME_BITS) begin
      swdio_oe_n = 1'b1;
    end else if (w_ack_win || (bit_cnt == BIT_TURN2)) begin
      swdio_oe_n = 1'b1;
    end else if (bit_cnt >= BIT_DATA0) begin
      swdio_oe_n = rnw | ack_ok_n;
    end
  end

  assign swdio = swdio_oe_n ? 1'bz : mosi;
  assign miso  = swdio;
  assign swclk = sck;

endmodule

// File: tb/tb_swd_frontend_top.sv
// Directed bench for swd_frontend_top with a frame-level ownership/ACK model.
module tb_swd_frontend_top;

  logic sck = 1'b0;
  logic rst_n, mosi, rnw;
  logic miso, swclk;
  logic tgt_en, tgt_v;
  wire  swdio;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] m_cnt;
  logic [2:0] m_ack;
  logic       m_rnw;
  logic       chk_en = 1'b0;

  assign swdio = tgt_en ? tgt_v : 1'bz;

  swd_frontend_top dut (
    .sck   (sck),
    .rst_n (rst_n),
    .mosi  (mosi),
    .rnw   (rnw),
    .miso  (miso),
    .swclk (swclk),
    .swdio (swdio)
  );

  always #5 sck = ~sck;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t, bit %0d)", name, act, exp, $time, m_cnt);
    end
  endtask

  // The host owns SWDIO for PAD/REQ, and for write data/parity only after an OK ACK.
  function automatic logic host_owns(input logic [5:0] k, input logic r, input logic [2:0] a);
    return (k < 6'd10) || (k >= 6'd15 && k <= 6'd47 && !r && a == 3'b001);
  endfunction

  // Per-cycle comparison, mid-way through the low phase of sck.
  initial begin
    logic       e_oe_n;
    logic [3:0] e_y;
    forever begin
      @(negedge sck);
      #3;
      if (chk_en) begin
        e_oe_n = !host_owns(m_cnt, m_rnw, m_ack);
        e_y    = 4'hf;
        if (m_cnt >= 6'd10 && m_cnt <= 6'd13) e_y[m_cnt - 6'd10] = 1'b0;
        check("bit_cnt", 32'(dut.bit_cnt), 32'(m_cnt));
        check("swdio_oe_n", 32'(dut.swdio_oe_n), 32'(e_oe_n));
        check("ack_regs", 32'({dut.ack2, dut.ack1, dut.ack0}), 32'(m_ack));
        check("ack_ok_n", 32'(dut.ack_ok_n), 32'(m_ack != 3'b001));
        check("y_n", 32'({dut.y5_n, dut.y4_n, dut.y3_n, dut.y2_n}), 32'(e_y));
        check("swclk", 32'(swclk), 32'(sck));
        if (!e_oe_n) begin
          check("swdio_host", 32'(swdio), 32'(mosi));
          check("miso_host", 32'(miso), 32'(mosi));
        end else if (tgt_en) begin
          check("miso_target", 32'(miso), 32'(tgt_v));
        end
      end
    end
  end

  // One bit period: inputs change on the falling edge, model advances after the rising edge.
  task automatic drive_bit(input logic m, input logic t_en, input logic t_v, input logic r);
    logic line;
    @(negedge sck);
    mosi   = m;
    tgt_en = t_en;
    tgt_v  = t_v;
    rst_n  = !r;
    @(posedge sck);
    #1;
    if (r) begin
      m_cnt = 6'd0;
      m_ack = 3'b000;
    end else begin
      line = host_owns(m_cnt, m_rnw, m_ack) ? m : t_v;
      if (m_cnt == 6'd11) m_ack[0] = line;
      if (m_cnt == 6'd12) m_ack[1] = line;
      if (m_cnt == 6'd13) m_ack[2] = line;
      if (m_cnt < 6'd48) m_cnt = m_cnt + 6'd1;
    end
  endtask

  task automatic reset_period(input logic r_nw);
    m_rnw = r_nw;
    rnw   = r_nw;
    drive_bit(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Bits k0..k1 of a frame; rst_at >= 0 asserts reset during that bit period.
  task automatic frame_bits(input logic r_nw, input logic [7:0] req, input logic [2:0] ack,
                            input logic [31:0] data, input int k0, input int k1, input int rst_at);
    logic m, te, tv;
    for (int k = k0; k <= k1; k++) begin
      m  = 1'(k & 1);
      te = 1'b0;
      tv = 1'b0;
      if (k <= 1)                     m = 1'b0;
      else if (k <= 9)                m = req[k-2];
      else if (k >= 11 && k <= 13)    begin te = 1'b1; tv = ack[k-11]; end
      else if (r_nw) begin
        if (k >= 14 && k <= 45)       begin te = 1'b1; tv = data[k-14]; end
        else if (k == 46)             begin te = 1'b1; tv = ^data; end
      end else begin
        if (k >= 15 && k <= 46)       m = data[k-15];
        else if (k == 47)             m = ^data;
      end
      drive_bit(m, te, tv, k == rst_at);
    end
  endtask

  initial begin
    rst_n = 1'b0; mosi = 1'b0; rnw = 1'b0; tgt_en = 1'b0; tgt_v = 1'b0;
    m_rnw = 1'b0; m_cnt = 6'd0; m_ack = 3'b000;
    repeat (2) @(posedge sck);
    #1;
    chk_en = 1'b1;

    // 1: OK write, with literal pins on ACK capture and PAD drive after reset
    reset_period(1'b0);
    check("lit_reset_cnt", 32'(dut.bit_cnt), 32'd0);
    check("lit_reset_oe_n", 32'(dut.swdio_oe_n), 32'd0);
    check("lit_reset_ack_ok_n", 32'(dut.ack_ok_n), 32'd1);
    frame_bits(1'b0, 8'hA1, 3'b001, 32'hCAFEBABE, 0, 13, -1);
    check("lit_ok_ack", 32'({dut.ack2, dut.ack1, dut.ack0}), 32'h1);
    check("lit_ok_ack_ok_n", 32'(dut.ack_ok_n), 32'd0);
    frame_bits(1'b0, 8'hA1, 3'b001, 32'hCAFEBABE, 14, 47, -1);

    // 6: keep clocking after the frame
    frame_bits(1'b0, 8'hA1, 3'b001, 32'hCAFEBABE, 48, 53, -1);
    check("lit_sat_cnt", 32'(dut.bit_cnt), 32'd48);
    check("lit_sat_oe_n", 32'(dut.swdio_oe_n), 32'd1);

    // 2: WAIT
    reset_period(1'b0);
    frame_bits(1'b0, 8'hA1, 3'b010, 32'hCAFEBABE, 0, 47, -1);
    check("lit_wait_ack", 32'({dut.ack2, dut.ack1, dut.ack0}), 32'h2);
    check("lit_wait_ack_ok_n", 32'(dut.ack_ok_n), 32'd1);

    // 3: FAULT
    reset_period(1'b0);
    frame_bits(1'b0, 8'hA1, 3'b100, 32'h0F0F1234, 0, 47, -1);
    check("lit_fault_ack", 32'({dut.ack2, dut.ack1, dut.ack0}), 32'h4);

    // 4: OK read, target drives data from bit 14
    reset_period(1'b1);
    frame_bits(1'b1, 8'hA5, 3'b001, 32'h12345678, 0, 47, -1);
    check("lit_read_ack_ok_n", 32'(dut.ack_ok_n), 32'd0);

    // 5: reset in the middle of an OK write, then a fresh frame
    reset_period(1'b0);
    frame_bits(1'b0, 8'hA1, 3'b001, 32'h55AA33CC, 0, 20, 20);
    check("lit_abort_cnt", 32'(dut.bit_cnt), 32'd0);
    check("lit_abort_ack", 32'({dut.ack2, dut.ack1, dut.ack0}), 32'h0);
    check("lit_abort_ack_ok_n", 32'(dut.ack_ok_n), 32'd1);
    check("lit_abort_oe_n", 32'(dut.swdio_oe_n), 32'd0);
    frame_bits(1'b0, 8'h3C, 3'b001, 32'h89ABCDEF, 0, 20, -1);

    @(negedge sck);
    #4;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
